// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the core and a wait-state word memory port.
// Define LSU_MISALIGN_EXC_EN to trap misaligned H/W accesses instead of masking the low address bits.
module riscv_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_size_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_wdata_i,
  output logic [31:0]       lsu_rdata_o,
  output logic              lsu_stall_o,
  output logic              lsu_misaligned_o,
  output logic              lsu_bus_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ready_i
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t            state_q, state_d;
  logic [9:0]        cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        off_q, off_d, off;
  logic              is_b, is_h, accepted, timeout;
  logic [31:0]       sh, ext;
  assign is_b = lsu_size_i[1:0] == 2'b00;
  assign is_h = lsu_size_i[1:0] == 2'b01;
`ifdef LSU_MISALIGN_EXC_EN
  logic mis;
  assign mis              = (is_h & lsu_addr_i[0]) | (!is_b & !is_h & |lsu_addr_i[1:0]);
  assign accepted         = !mis;
  assign lsu_misaligned_o = lsu_req_i & mis & (state_q == IDLE);
  assign off              = lsu_addr_i[1:0];
`else
  assign accepted         = 1'b1;
  assign lsu_misaligned_o = 1'b0;
  assign off              = is_b ? lsu_addr_i[1:0] : is_h ? {lsu_addr_i[1], 1'b0} : 2'b00;
`endif
  // Error fires on the TIMEOUT-th non-ready REQ cycle; a simultaneous ready takes priority.
  assign timeout       = (TIMEOUT != 0) && (cnt_q == 10'(TIMEOUT - 1));
  assign lsu_bus_err_o = (state_q == REQ) & !mem_ready_i & timeout;
  assign lsu_stall_o   = lsu_req_i & accepted & (state_q != DONE);
  assign sh  = mem_rdata_i >> {off_q, 3'b000};
  assign ext = size_q[1:0] == 2'b00 ? (size_q[2] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]}) :
               size_q[1:0] == 2'b01 ? (size_q[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]}) :
               mem_rdata_i;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (lsu_req_i && accepted) begin
        state_d = REQ;
        cnt_d   = '0;
        we_d    = lsu_we_i;
        be_d    = is_b ? 4'b0001 << off : is_h ? 4'b0011 << off : 4'b1111;
        addr_d  = {lsu_addr_i[ADDR_W-1:2], 2'b00};
        wdata_d = is_b ? {4{lsu_wdata_i[7:0]}} : is_h ? {2{lsu_wdata_i[15:0]}} : lsu_wdata_i;
        size_d  = lsu_size_i;
        off_d   = off;
      end
      REQ: if (mem_ready_i) begin
        state_d = DONE;
        rdata_d = we_q ? rdata_q : ext;
      end else if (timeout) begin
        state_d = DONE;
        rdata_d = '0;
      end else begin
        cnt_d = cnt_q + 10'd1;
      end
      default: state_d = IDLE;
    endcase
    req_d = state_d == REQ;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      off_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
    end
  end
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign lsu_rdata_o = rdata_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed and random accesses against a byte-lane reference model.
module tb_riscv_lsu;
  localparam int TO = 4;
  logic        clk = 0, rst_n = 0;
  logic        lsu_req_i = 0, lsu_we_i = 0, mem_ready_i = 0;
  logic [2:0]  lsu_size_i = 0;
  logic [31:0] lsu_addr_i = 0, lsu_wdata_i = 0, mem_rdata_i = 0;
  logic [31:0] lsu_rdata_o, mem_addr_o, mem_wdata_o;
  logic        lsu_stall_o, lsu_misaligned_o, lsu_bus_err_o, mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  int          n_cmp = 0, n_fail = 0;
  logic [31:0] exp_rdata = 0;
  riscv_lsu #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i),
    .lsu_size_i(lsu_size_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_rdata_o(lsu_rdata_o), .lsu_stall_o(lsu_stall_o), .lsu_misaligned_o(lsu_misaligned_o),
    .lsu_bus_err_o(lsu_bus_err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // One full access; the model derives lanes from the access width, not from any RTL encoding.
  task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rw, input int waits);
    int bytes, off, k;
    logic sgn, mis, rdy, err;
    logic [31:0] al, val, mask, ewd;
    logic [3:0] ebe;
    bytes = sz[1:0] == 2'b00 ? 1 : sz[1:0] == 2'b01 ? 2 : 4;
    sgn   = !sz[2];
    mis   = (addr % bytes) != 0;
    al    = addr - addr % bytes;
    off   = al % 4;
    ebe   = 4'(((1 << bytes) - 1) << off);
    for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % bytes) +: 8];
    val = rw >> (8 * off);
    if (bytes < 4) begin
      mask = (32'd1 << (8 * bytes)) - 1;
      val  = val & mask;
      if (sgn && val[8*bytes-1]) val = val | ~mask;
    end
    @(negedge clk);
    lsu_req_i = 1; lsu_we_i = we; lsu_size_i = sz; lsu_addr_i = addr; lsu_wdata_i = wd;
    mem_rdata_i = rw; mem_ready_i = 0;
    #1;
`ifdef LSU_MISALIGN_EXC_EN
    if (mis) begin
      check("mis_flag", 32'(lsu_misaligned_o), 1);
      check("mis_stall", 32'(lsu_stall_o), 0);
      @(negedge clk); #1;
      check("mis_noreq", 32'(mem_req_o), 0);
      lsu_req_i = 0;
      return;
    end
`endif
    check("idle_stall", 32'(lsu_stall_o), 1);
    check("idle_mis", 32'(lsu_misaligned_o), 0);
    check("idle_noreq", 32'(mem_req_o), 0);
    err = 0;
    for (k = 1; k < 1100; k++) begin
      @(negedge clk);
      rdy = k == waits + 1;
      mem_ready_i = rdy;
      #1;
      check("req", 32'(mem_req_o), 1);
      check("we", 32'(mem_we_o), 32'(we));
      check("be", 32'(mem_be_o), 32'(ebe));
      check("addr", mem_addr_o, al & ~32'd3);
      check("wdata", mem_wdata_o, ewd);
      check("req_stall", 32'(lsu_stall_o), 1);
      err = !rdy && k == TO;
      check("bus_err", 32'(lsu_bus_err_o), 32'(err));
      if (rdy || err) break;
    end
    @(negedge clk);
    mem_ready_i = 0;
    #1;
    if (err) exp_rdata = 0;
    else if (!we) exp_rdata = val;
    check("rdata", lsu_rdata_o, exp_rdata);
    check("done_stall", 32'(lsu_stall_o), 0);
    check("done_noreq", 32'(mem_req_o), 0);
    check("done_err", 32'(lsu_bus_err_o), 0);
    lsu_req_i = 0;
  endtask
  initial begin
    #12;
    check("rst_req", 32'(mem_req_o), 0);
    check("rst_we", 32'(mem_we_o), 0);
    check("rst_be", 32'(mem_be_o), 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_wdata", mem_wdata_o, 0);
    check("rst_rdata", lsu_rdata_o, 0);
    check("rst_err", 32'(lsu_bus_err_o), 0);
    check("rst_stall", 32'(lsu_stall_o), 0);
    @(negedge clk); rst_n = 1;
    access(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0);
    access(0, 3'b000, 32'h103, 0, 32'h80FFFFFF, 2);
    access(0, 3'b100, 32'h103, 0, 32'h80FFFFFF, 2);
    access(1, 3'b001, 32'h102, 32'h1234ABCD, 0, 1);
    access(0, 3'b010, 32'h104, 0, 32'h11112222, 10);
    access(0, 3'b101, 32'h106, 0, 32'h9ABC0000, TO - 1);
    access(0, 3'b010, 32'h102, 0, 32'hCAFEF00D, 0);
    access(0, 3'b001, 32'h201, 0, 32'h0000F00D, 0);
    // Reset in the second wait cycle of a load abandons it immediately.
    @(negedge clk);
    lsu_req_i = 1; lsu_we_i = 0; lsu_size_i = 3'b010; lsu_addr_i = 32'h300; mem_ready_i = 0;
    @(negedge clk);
    @(negedge clk); #1;
    check("pre_rst_req", 32'(mem_req_o), 1);
    rst_n = 0; #1;
    exp_rdata = 0;
    check("async_req", 32'(mem_req_o), 0);
    check("async_rdata", lsu_rdata_o, 0);
    lsu_req_i = 0;
    @(negedge clk); rst_n = 1;
    access(0, 3'b010, 32'h300, 0, 32'h0BADC0DE, 1);
    for (int i = 0; i < 150; i++)
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 5)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit between the single-cycle RISC-V core's execute stage and a wait-state data memory port. It takes the ALU-computed address, store data and funct3-encoded access size from the core, and drives a word-organised memory bus with byte enables. It stalls the core (PC hold) until the memory answers, then returns load data that is lane-extracted and sign- or zero-extended. A bounded wait counter converts a hung bus into an error.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of lsu_addr_i / mem_addr_o.
- TIMEOUT, 255, maximum cycles spent waiting for mem_ready_i; 0 disables the timeout; legal 0..1023.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lsu_req_i  in  1  core requests a memory access; held stable while lsu_stall_o=1.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_size_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 treated as W.
- lsu_addr_i  in  ADDR_W  byte address (ALU result).
- lsu_wdata_i  in  32  store data (rs2).
- lsu_rdata_o  out  32  extended load data, valid in DONE.
- lsu_stall_o  out  1  hold PC and writeback.
- lsu_misaligned_o  out  1  misaligned-access flag (see Configuration).
- lsu_bus_err_o  out  1  one-cycle pulse on timeout.
- mem_req_o  out  1  memory request, held until mem_ready_i.
- mem_we_o  out  1  write strobe qualifier.
- mem_be_o  out  4  byte enables.
- mem_addr_o  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- mem_wdata_o  out  32  lane-replicated store data.
- mem_rdata_i  in  32  read word.
- mem_ready_i  in  1  access complete this cycle.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: when lsu_req_i=1 and the access is accepted, register the word address, byte enables, write data, we, size and addr[1:0], then go to REQ.
- REQ: mem_req_o=1 with the registered fields.
  - If mem_ready_i=1: capture the extended mem_rdata_i into lsu_rdata_o and go to DONE.
  - If the wait counter reaches TIMEOUT: pulse lsu_bus_err_o, set lsu_rdata_o=0, go to DONE.
- DONE: lsu_stall_o=0; the core retires at this edge; go to IDLE unconditionally.
- lsu_stall_o = lsu_req_i & accepted & (state != DONE). It is combinational in IDLE.
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0].
  - H/HU: 4'b0011 << {addr[1],1'b0}.
  - W: 4'b1111.
- Store data replication: byte replicated ×4, half replicated ×2, word passed through.
- Load data: mem_rdata_i >> (8*addr[1:0]), then sign-extend (B, H) or zero-extend (BU, HU); W passes through.
- Wait counter: 10 bits, cleared on entering REQ, increments each REQ cycle without ready.
- Stores write nothing to lsu_rdata_o (it keeps its previous value).

## Timing
- Reset values: state=IDLE, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, lsu_rdata_o=0, lsu_bus_err_o=0, counter=0.
- With zero-wait memory (mem_ready_i high in the first REQ cycle), latency is 3 cycles: cycle 0 IDLE (stall), cycle 1 REQ (stall), cycle 2 DONE (no stall, data valid).
- Each wait cycle adds one cycle.
- mem_* outputs are registered; mem_req_o is never asserted in IDLE or DONE.
- The request is not re-issued in DONE even though lsu_req_i is still high that cycle.
- Reset asserted mid-REQ: mem_req_o drops immediately (asynchronous), and the in-flight transaction is abandoned.
- Timeout: the bus error pulse occurs on the TIMEOUT-th consecutive non-ready REQ cycle; mem_req_o deasserts the next cycle.
- mem_ready_i and timeout in the same cycle: ready wins, and no error is flagged.

## Configuration
- LSU_MISALIGN_EXC_EN defined: an H/HU access with addr[0]=1, or a W access with addr[1:0]≠0, sets lsu_misaligned_o=1 (combinational, IDLE only).
  - No memory transaction is issued and lsu_stall_o=0.
  - The core treats the access as trapped.
- Undefined: lsu_misaligned_o is tied to 0, and low address bits are masked to natural alignment (H clears bit 0, W clears bits [1:0]) before the access proceeds.

## Test plan
- LW at 0x100, memory returns 0xDEADBEEF with zero wait → stall in cycles 0–1; cycle 2 lsu_rdata_o=0xDEADBEEF, mem_be_o=1111.
- LB at 0x103, word 0x80FF_FFFF, 2 wait states → mem_be_o=1000, rdata=0xFFFFFF80, stall lasts 4 cycles. Same access as LBU → 0x00000080.
- SH at 0x102, wdata 0x1234ABCD → mem_we_o=1, mem_be_o=1100, mem_wdata_o=0xABCDABCD, mem_addr_o=0x100.
- TIMEOUT=4, mem_ready_i held 0 → lsu_bus_err_o pulses in the 4th REQ cycle, then DONE with rdata=0; mem_req_o low afterwards.
- LW at 0x102 with LSU_MISALIGN_EXC_EN → lsu_misaligned_o=1, mem_req_o never asserted. Without the macro → access at 0x100, be=1111.
- rst_n pulled low in the 2nd wait cycle of a load → mem_req_o=0 at once; after release, state is IDLE and a new LW completes normally.
